gmii_rx_ctrl: RTL and testbench

Receive-frame controller behind the RGMII-to-GMII receive stage; runs in the recovered GMII receive clock domain. Detects preamble/SFD, strips them and forwards frame bytes as a framed byte stream (sof/eof). Checks length and destination address and reports a per-frame status word plus saturating good/bad frame counters. Feeds the UDP/IP receive parser and the loopback FIFO.

---
 rtl/gmii_rx_pkg.sv | 38 +++
 rtl/gmii_rx_ctrl_crc32_d8.sv | 33 +++
 rtl/gmii_rx_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_gmii_rx_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive-frame controller.
// The CRC_ERR status bit is driven only when RX_CRC_CHECK_EN is defined.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam int RUNT          = 0;
    localparam int OVERSIZE      = 1;
    localparam int ADDR_MISMATCH = 2;
    localparam int CRC_ERR       = 3;

    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [7:0]  PRE         = 8'h55;
    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

    // MSB-first shift register fed LSB-first from each byte, so a frame with a
    // correct FCS leaves the register at CRC_RESIDUE.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/gmii_rx_ctrl_crc32_d8.sv
// Byte-wide CRC-32 accumulator: combinational next-state plus its register.
// Built only when RX_CRC_CHECK_EN is defined.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_reg;
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc32_step(crc_reg, data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= '1;
        end else if (init) begin
            crc_reg <= '1;
        end else if (en) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/gmii_rx_ctrl.sv
// GMII receive-frame controller: strips preamble/SFD, forwards a framed byte
// stream and reports per-frame status. Optional CRC check: RX_CRC_CHECK_EN.
module gmii_rx_ctrl
    import gmii_rx_pkg::*;
#(
    parameter int PRE_MIN = 6,
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gmii_rx_dv,
    input  logic [7:0]       gmii_rxd,
    input  logic [47:0]      local_mac,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic [3:0]       frame_status,
    output logic [15:0]      good_cnt,
    output logic [15:0]      bad_cnt
);

    state_t           state_reg;
    logic [2:0]       pre_cnt_reg;
    logic [LEN_W-1:0] len_reg;
    logic [7:0]       hold_reg;
    logic             uni_ok_reg;
    logic             bc_ok_reg;
    logic             done_pend_reg;
    logic [LEN_W-1:0] done_len_reg;
    logic [3:0]       done_status_reg;

    logic             at_max;
    logic [LEN_W-1:0] end_len;
    logic [3:0]       end_status;
    logic             end_crc_err;
    logic [7:0]       mac_bytes [0:7];

    // Destination-address byte i lines up with local_mac[47-8i -: 8].
    for (genvar gi = 0; gi < 8; gi++) begin : g_mac_bytes
        if (gi < 6) begin : g_real
            assign mac_bytes[gi] = local_mac[47-8*gi -: 8];
        end else begin : g_pad
            assign mac_bytes[gi] = 8'h00;
        end
    end

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc_val;

    crc32_d8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (state_reg != DATA),
        .en   (state_reg == DATA && gmii_rx_dv && !at_max),
        .data (gmii_rxd),
        .crc  (crc_val)
    );

    assign end_crc_err = (crc_val != CRC_RESIDUE) || (len_reg < LEN_W'(4));
`else
    assign end_crc_err = 1'b0;
`endif

    assign at_max  = (len_reg == LEN_W'(MAX_LEN));
    // A frame ending while dv is still high can only be the oversize cut-off.
    assign end_len = gmii_rx_dv ? LEN_W'(MAX_LEN + 1) : len_reg;

    always_comb begin
        end_status                = '0;
        end_status[RUNT]          = end_len < LEN_W'(MIN_LEN);
        end_status[OVERSIZE]      = gmii_rx_dv;
        end_status[ADDR_MISMATCH] = (end_len < LEN_W'(6)) || !(uni_ok_reg || bc_ok_reg);
        end_status[CRC_ERR]       = end_crc_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            pre_cnt_reg     <= '0;
            len_reg         <= '0;
            hold_reg        <= '0;
            uni_ok_reg      <= 1'b0;
            bc_ok_reg       <= 1'b0;
            done_pend_reg   <= 1'b0;
            done_len_reg    <= '0;
            done_status_reg <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_sof         <= 1'b0;
            out_eof         <= 1'b0;
            frame_done      <= 1'b0;
            frame_len       <= '0;
            frame_status    <= '0;
            good_cnt        <= '0;
            bad_cnt         <= '0;
        end else begin
            out_valid     <= 1'b0;
            out_sof       <= 1'b0;
            out_eof       <= 1'b0;
            frame_done    <= 1'b0;
            done_pend_reg <= 1'b0;

            // Report stage runs independently of the FSM so a new preamble
            // can start while the previous frame is being reported.
            if (done_pend_reg) begin
                frame_done   <= 1'b1;
                frame_len    <= done_len_reg;
                frame_status <= done_status_reg;
                if (done_status_reg == 4'd0) begin
                    if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
                end else begin
                    if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == PRE) begin
                            state_reg   <= PREAMBLE;
                            pre_cnt_reg <= 3'd1;
                        end else begin
                            state_reg <= DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_reg <= IDLE;
                    end else if (gmii_rxd == PRE) begin
                        if (pre_cnt_reg != 3'd7) pre_cnt_reg <= pre_cnt_reg + 3'd1;
                    end else if (gmii_rxd == SFD && 32'(pre_cnt_reg) >= PRE_MIN) begin
                        state_reg  <= DATA;
                        len_reg    <= '0;
                        uni_ok_reg <= 1'b1;
                        bc_ok_reg  <= 1'b1;
                    end else begin
                        state_reg <= DROP;
                    end
                end

                DATA: begin
                    if (gmii_rx_dv && !at_max) begin
                        hold_reg <= gmii_rxd;
                        len_reg  <= len_reg + LEN_W'(1);
                        if (len_reg < LEN_W'(6)) begin
                            uni_ok_reg <= uni_ok_reg && (gmii_rxd == mac_bytes[len_reg[2:0]]);
                            bc_ok_reg  <= bc_ok_reg && (gmii_rxd == BCAST_MAC[7:0]);
                        end
                        if (len_reg != '0) begin
                            out_valid <= 1'b1;
                            out_data  <= hold_reg;
                            out_sof   <= (len_reg == LEN_W'(1));
                        end
                    end else begin
                        // End of frame: dv fell, or the oversize byte arrived.
                        if (len_reg != '0) begin
                            out_valid <= 1'b1;
                            out_data  <= hold_reg;
                            out_sof   <= (len_reg == LEN_W'(1));
                            out_eof   <= 1'b1;
                        end
                        done_pend_reg   <= 1'b1;
                        done_len_reg    <= end_len;
                        done_status_reg <= end_status;
                        state_reg       <= gmii_rx_dv ? DROP : IDLE;
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv) state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_ctrl.sv
// Scoreboard bench for gmii_rx_ctrl: stimulus pushes expected beats/reports,
// a monitor pops and compares them as the DUT presents them.
module tb_gmii_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic [47:0] local_mac;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        frame_done;
    logic [10:0] frame_len;
    logic [3:0]  frame_status;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

`ifdef RX_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    localparam logic [47:0] MY_MAC = 48'h000A_3501_FEC0;

    gmii_rx_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rxd     (gmii_rxd),
        .local_mac    (local_mac),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .frame_done   (frame_done),
        .frame_len    (frame_len),
        .frame_status (frame_status),
        .good_cnt     (good_cnt),
        .bad_cnt      (bad_cnt)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } beat_t;

    typedef struct {
        logic [10:0] len;
        logic [3:0]  status;
        logic [15:0] good;
        logic [15:0] bad;
    } done_t;

    beat_t      beat_q[$];
    done_t      done_q[$];
    logic [7:0] frm[$];
    int         total = 0;
    int         bad = 0;
    int         exp_good = 0;
    int         exp_bad = 0;
    int         beat_no = 0;
    bit         ignore_out = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitor: compares every presented beat and frame report.
    initial begin
        forever begin
            @(negedge clk);
            if (!ignore_out && rst === 1'b0) begin
                if (out_valid) begin
                    if (beat_q.size() == 0) begin
                        fail_now("unexpected_beat", {out_sof, out_eof, out_data});
                    end else begin
                        beat_t b;
                        b = beat_q.pop_front();
                        total++;
                        if ({out_sof, out_eof, out_data} !== {b.sof, b.eof, b.data}) begin
                            bad++;
                            $display("FAIL beat%0d: got sof=%0d eof=%0d data=%02h expected sof=%0d eof=%0d data=%02h",
                                     beat_no, out_sof, out_eof, out_data, b.sof, b.eof, b.data);
                        end
                        beat_no++;
                    end
                end
                if (frame_done) begin
                    if (done_q.size() == 0) begin
                        fail_now("unexpected_done", {frame_len, frame_status});
                    end else begin
                        done_t d;
                        d = done_q.pop_front();
                        check("frame_len", 64'(frame_len), 64'(d.len));
                        check("frame_status", 64'(frame_status), 64'(d.status));
                        check("counters", {32'h0, good_cnt, bad_cnt}, {32'h0, d.good, d.bad});
                    end
                end
            end
        end
    end

    task automatic drive(input logic dv, input logic [7:0] d);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
    endtask

    // Frame = dst, fixed src, pattern payload, optional correct FCS.
    task automatic build(input logic [47:0] dst, input int n, input bit with_fcs);
        logic [47:0] src;
        logic [31:0] c;
        int body;
        src = 48'h000A_35AA_BBCC;
        body = with_fcs ? n - 4 : n;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        for (int i = 12; i < body; i++) frm.push_back(8'((i * 7 + 3) & 255));
        if (with_fcs) begin
            c = 32'hFFFF_FFFF;
            foreach (frm[k]) begin
                c = c ^ {24'h0, frm[k]};
                for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
            c = ~c;
            frm.push_back(c[7:0]);
            frm.push_back(c[15:8]);
            frm.push_back(c[23:16]);
            frm.push_back(c[31:24]);
        end
    endtask

    task automatic expect_frame(input int nbeats, input int len, input logic [3:0] status);
        done_t d;
        for (int i = 0; i < nbeats; i++) begin
            beat_t b;
            b.data = frm[i];
            b.sof  = (i == 0);
            b.eof  = (i == nbeats - 1);
            beat_q.push_back(b);
        end
        if (status == 4'd0) exp_good++;
        else exp_bad++;
        d.len    = 11'(len);
        d.status = status;
        d.good   = 16'(exp_good);
        d.bad    = 16'(exp_bad);
        done_q.push_back(d);
    endtask

    task automatic send(input int npre, input int gap);
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        foreach (frm[k]) drive(1'b1, frm[k]);
        for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && (beat_q.size() != 0 || done_q.size() != 0); i++) @(posedge clk);
        if (beat_q.size() != 0 || done_q.size() != 0) begin
            fail_now({name, "_timeout"}, 64'(beat_q.size() + done_q.size()));
            beat_q.delete();
            done_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        local_mac  = MY_MAC;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {out_valid, out_data, out_sof, out_eof, frame_done, frame_len, frame_status, good_cnt, bad_cnt}, 64'h0);
        rst = 1'b0;

        build(MY_MAC, 64, 1'b1);
        expect_frame(64, 64, 4'b0000);
        send(7, 3);
        drain("good64");

        build(48'hFFFF_FFFF_FFFF, 60, 1'b1);
        expect_frame(60, 60, 4'b0001);
        send(7, 3);
        drain("bcast_runt");

        build(48'h1122_3344_5566, 100, 1'b1);
        expect_frame(100, 100, 4'b0100);
        send(7, 3);
        drain("mismatch100");

        build(MY_MAC, 1600, 1'b0);
        expect_frame(1518, 1519, {CRC_ON, 1'b0, 1'b1, 1'b0});
        send(7, 3);
        drain("oversize");

        build(MY_MAC, 64, 1'b1);
        expect_frame(64, 64, 4'b0000);
        send(6, 3);
        drain("after_oversize");

        // Preamble aborts: none of these may produce output or a report.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        drive(1'b1, 8'h11);
        drive(1'b0, 8'h00);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h13);
        drive(1'b1, 8'h22);
        drive(1'b0, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        check("abort_counters", {good_cnt, bad_cnt}, {16'(exp_good), 16'(exp_bad)});
        check("abort_len_held", 64'(frame_len), 64'd64);

        frm.delete();
        expect_frame(0, 0, {CRC_ON, 1'b1, 1'b0, 1'b1});
        send(7, 3);
        drain("sfd_only");

        frm.delete();
        frm.push_back(8'h42);
        expect_frame(1, 1, {CRC_ON, 1'b1, 1'b0, 1'b1});
        send(7, 3);
        drain("one_byte");

        build(MY_MAC, 64, 1'b1);
        expect_frame(64, 64, 4'b0000);
        send(7, 1);
        build(48'hFFFF_FFFF_FFFF, 64, 1'b1);
        expect_frame(64, 64, 4'b0000);
        send(7, 3);
        drain("back_to_back");

        build(MY_MAC, 64, 1'b1);
        frm[20] = frm[20] ^ 8'h01;
        expect_frame(64, 64, {CRC_ON, 3'b000});
        send(7, 3);
        drain("crc_flip");

        // Reset in the middle of a frame.
        ignore_out = 1'b1;
        build(MY_MAC, 64, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, frm[i]);
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {out_valid, out_data, out_sof, out_eof, frame_done, frame_len, frame_status, good_cnt, bad_cnt}, 64'h0);
        gmii_rx_dv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        ignore_out = 1'b0;
        exp_good   = 0;
        exp_bad    = 0;
        beat_q.delete();
        done_q.delete();

        build(MY_MAC, 64, 1'b1);
        expect_frame(64, 64, 4'b0000);
        send(7, 3);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
